// File: rtl/sensor_alarm_qualifier.sv
// Sensor front end for the fire-alarm path: qualifies DHT temperature/humidity
// readings with hysteresis and N-sample confirmation, filters the smoke pin and flags stale sensors.

module sensor_alarm_channel #(
    parameter logic [7:0] HI        = 8'd50,
    parameter logic [7:0] LO        = 8'd45,
    parameter int         CONFIRM_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [7:0] data,
    output logic       flag
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_ALARM  = 1'b1
    } state_t;

    // cc counts qualifying samples already seen, so the N-th one arrives when cc == N-1
    localparam logic [3:0] CONFIRM_LAST = 4'(CONFIRM_N - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cc_q;
    logic [3:0] cc_d;
    logic       flag_q;
    logic       flag_d;

    // State, confirm counter and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            cc_q    <= 4'd0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            flag_q  <= flag_d;
        end
    end

    // Next state: count consecutive qualifying accepted samples, any other sample restarts the count
    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        if (accept) begin
            case (state_q)
                ST_NORMAL: begin
                    if (data >= HI) begin
                        if (cc_q == CONFIRM_LAST) begin
                            state_d = ST_ALARM;
                            cc_d    = 4'd0;
                        end else begin
                            cc_d    = cc_q + 4'd1;
                        end
                    end else begin
                        cc_d = 4'd0;
                    end
                end
                ST_ALARM: begin
                    if (data <= LO) begin
                        if (cc_q == CONFIRM_LAST) begin
                            state_d = ST_NORMAL;
                            cc_d    = 4'd0;
                        end else begin
                            cc_d    = cc_q + 4'd1;
                        end
                    end else begin
                        cc_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    cc_d    = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
            cc_d    = cc_q;
        end
    end

    // Output: flag mirrors the next state so it is registered alongside it
    always_comb begin
        flag_d = 1'b0;
        if (state_d == ST_ALARM) begin
            flag_d = 1'b1;
        end else begin
            flag_d = 1'b0;
        end
    end

    assign flag = flag_q;

endmodule

module sensor_alarm_qualifier #(
    parameter int         CLK_FREQ     = 40_000_000,
    parameter logic [7:0] TEMP_HI      = 8'd50,
    parameter logic [7:0] TEMP_LO      = 8'd45,
    parameter logic [7:0] HUM_HI       = 8'd90,
    parameter logic [7:0] HUM_LO       = 8'd85,
    parameter int         CONFIRM_N    = 3,
    parameter int         SMOKE_FILT   = CLK_FREQ / 100 - 1,
    parameter int         STALE_CYCLES = CLK_FREQ * 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic       data_err,
    input  logic [7:0] temp_data,
    input  logic [7:0] hum_data,
    input  logic       smoke_raw,
    output logic       temp,
    output logic       hum,
    output logic       smoke,
    output logic       sensor_fault,
    output logic [7:0] sample_cnt
);

    localparam logic [31:0] FILT_LAST = (SMOKE_FILT > 0) ? 32'(SMOKE_FILT - 1) : 32'd0;
    localparam logic [31:0] STALE_LIM = 32'(STALE_CYCLES);

    logic        accept_s;
    logic [7:0]  sample_cnt_q;
    logic [7:0]  sample_cnt_d;
    logic        sync1_q;
    logic        sync1_d;
    logic        s_sync_q;
    logic        s_sync_d;
    logic        smoke_q;
    logic        smoke_d;
    logic [31:0] filt_cnt_q;
    logic [31:0] filt_cnt_d;
    logic [31:0] stale_q;
    logic [31:0] stale_d;
    logic        fault_q;
    logic        fault_d;

    assign accept_s = data_valid & ~data_err;

    sensor_alarm_channel #(
        .HI        (TEMP_HI),
        .LO        (TEMP_LO),
        .CONFIRM_N (CONFIRM_N)
    ) u_temp (
        .clk    (clk),
        .rst    (rst),
        .accept (accept_s),
        .data   (temp_data),
        .flag   (temp)
    );

    sensor_alarm_channel #(
        .HI        (HUM_HI),
        .LO        (HUM_LO),
        .CONFIRM_N (CONFIRM_N)
    ) u_hum (
        .clk    (clk),
        .rst    (rst),
        .accept (accept_s),
        .data   (hum_data),
        .flag   (hum)
    );

    // Sample counter, smoke synchronizer/filter and stale-timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= 8'd0;
            sync1_q      <= 1'b0;
            s_sync_q     <= 1'b0;
            smoke_q      <= 1'b0;
            filt_cnt_q   <= 32'd0;
            stale_q      <= 32'd0;
            fault_q      <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            sync1_q      <= sync1_d;
            s_sync_q     <= s_sync_d;
            smoke_q      <= smoke_d;
            filt_cnt_q   <= filt_cnt_d;
            stale_q      <= stale_d;
            fault_q      <= fault_d;
        end
    end

    // Accepted-sample counter wraps naturally at 8 bits
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (accept_s) begin
            sample_cnt_d = sample_cnt_q + 8'd1;
        end else begin
            sample_cnt_d = sample_cnt_q;
        end
    end

    // Smoke: a level differing from the accepted one must persist SMOKE_FILT cycles
    always_comb begin
        sync1_d    = smoke_raw;
        s_sync_d   = sync1_q;
        smoke_d    = smoke_q;
        filt_cnt_d = 32'd0;
        if (s_sync_q == smoke_q) begin
            filt_cnt_d = 32'd0;
        end else if (filt_cnt_q >= FILT_LAST) begin
            smoke_d    = s_sync_q;
            filt_cnt_d = 32'd0;
        end else begin
            filt_cnt_d = filt_cnt_q + 32'd1;
        end
    end

    // Stale timer saturates; an accepted sample always wins over reaching the limit
    always_comb begin
        stale_d = stale_q;
        fault_d = 1'b0;
        if (accept_s) begin
            stale_d = 32'd0;
            fault_d = 1'b0;
        end else if (stale_q >= STALE_LIM) begin
            stale_d = STALE_LIM;
            fault_d = 1'b1;
        end else begin
            stale_d = stale_q + 32'd1;
            fault_d = ((stale_q + 32'd1) >= STALE_LIM);
        end
    end

    assign smoke        = smoke_q;
    assign sensor_fault = fault_q;
    assign sample_cnt   = sample_cnt_q;

endmodule

// File: tb/tb_sensor_alarm_qualifier.sv
// Self-checking bench for sensor_alarm_qualifier: directed scenarios plus randomized traffic,
// checked every cycle against a history-based behavioural model.

module tb_sensor_alarm_qualifier;

    localparam int         CONF  = 3;
    localparam int         FILT  = 4;
    localparam int         STALE = 100;
    localparam logic [7:0] T_HI  = 8'd50;
    localparam logic [7:0] T_LO  = 8'd45;
    localparam logic [7:0] H_HI  = 8'd90;
    localparam logic [7:0] H_LO  = 8'd85;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       dv_i = 1'b0;
    logic       err_i = 1'b0;
    logic [7:0] td_i = 8'd0;
    logic [7:0] hd_i = 8'd0;
    logic       raw_i = 1'b0;
    logic       temp;
    logic       hum;
    logic       smoke;
    logic       sensor_fault;
    logic [7:0] sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state
    logic [7:0] t_hist[$];
    logic [7:0] h_hist[$];
    bit         s_hist[$];
    int         t_mark, h_mark, s_mark;
    bit         m_temp, m_hum, m_smoke, m_fault;
    bit         m_sync1, m_sync2;
    int         m_cnt, m_idle;

    always #5 clk = ~clk;

    sensor_alarm_qualifier #(
        .CLK_FREQ     (40_000_000),
        .TEMP_HI      (T_HI),
        .TEMP_LO      (T_LO),
        .HUM_HI       (H_HI),
        .HUM_LO       (H_LO),
        .CONFIRM_N    (CONF),
        .SMOKE_FILT   (FILT),
        .STALE_CYCLES (STALE)
    ) dut (
        .clk          (clk),
        .rst          (rst_i),
        .data_valid   (dv_i),
        .data_err     (err_i),
        .temp_data    (td_i),
        .hum_data     (hd_i),
        .smoke_raw    (raw_i),
        .temp         (temp),
        .hum          (hum),
        .smoke        (smoke),
        .sensor_fault (sensor_fault),
        .sample_cnt   (sample_cnt)
    );

    function automatic bit qualifies(bit flag, logic [7:0] v, logic [7:0] hi, logic [7:0] lo);
        return flag ? (v <= lo) : (v >= hi);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        t_hist.delete(); h_hist.delete(); s_hist.delete();
        t_mark = 0; h_mark = 0; s_mark = 0;
        m_temp = 0; m_hum = 0; m_smoke = 0; m_fault = 0;
        m_sync1 = 0; m_sync2 = 0; m_cnt = 0; m_idle = 0;
    endtask

    // Model: a flag flips when the last CONF accepted samples since its previous flip all qualify
    task automatic model_update();
        bit s;
        bit ok;
        if (rst_i) begin
            model_reset();
        end else begin
            s = m_sync2;
            m_sync2 = m_sync1;
            m_sync1 = raw_i;
            s_hist.push_back(s);
            ok = (s_hist.size() - s_mark) >= FILT;
            for (int k = 1; ok && k <= FILT; k++)
                if (s_hist[s_hist.size() - k] == m_smoke) ok = 0;
            if (ok) begin
                m_smoke = ~m_smoke;
                s_mark  = s_hist.size();
            end
            if (dv_i && !err_i) begin
                t_hist.push_back(td_i);
                h_hist.push_back(hd_i);
                m_cnt  = (m_cnt + 1) % 256;
                m_idle = 0;
                ok = (t_hist.size() - t_mark) >= CONF;
                for (int k = 1; ok && k <= CONF; k++)
                    if (!qualifies(m_temp, t_hist[t_hist.size() - k], T_HI, T_LO)) ok = 0;
                if (ok) begin
                    m_temp = ~m_temp;
                    t_mark = t_hist.size();
                end
                ok = (h_hist.size() - h_mark) >= CONF;
                for (int k = 1; ok && k <= CONF; k++)
                    if (!qualifies(m_hum, h_hist[h_hist.size() - k], H_HI, H_LO)) ok = 0;
                if (ok) begin
                    m_hum  = ~m_hum;
                    h_mark = h_hist.size();
                end
            end else begin
                m_idle++;
            end
            m_fault = (m_idle >= STALE);
        end
    endtask

    // One clock: update the model at the edge, compare every output on the falling edge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check("temp", 32'(temp), 32'(m_temp));
        check("hum", 32'(hum), 32'(m_hum));
        check("smoke", 32'(smoke), 32'(m_smoke));
        check("sensor_fault", 32'(sensor_fault), 32'(m_fault));
        check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic sample(logic [7:0] t, logic [7:0] h, logic err);
        dv_i = 1'b1; err_i = err; td_i = t; hd_i = h;
        step();
        dv_i = 1'b0; err_i = 1'b0;
    endtask

    function automatic logic [7:0] pick(logic [7:0] hi, logic [7:0] lo);
        case ($urandom_range(0, 7))
            0: return hi;
            1: return hi + 8'd1;
            2: return hi - 8'd1;
            3: return lo;
            4: return lo + 8'd1;
            5: return lo - 8'd1;
            6: return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        model_reset();
        // reset
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("reset_temp", 32'(temp), 32'd0);
        check("reset_cnt", 32'(sample_cnt), 32'd0);

        // 1: three over-temperature samples set temp
        sample(8'd52, 8'd20, 1'b0); idle(9);
        sample(8'd52, 8'd20, 1'b0);
        check("t1_temp_after2", 32'(temp), 32'd0);
        idle(9);
        sample(8'd52, 8'd20, 1'b0);
        check("t1_temp_after3", 32'(temp), 32'd1);
        check("t1_cnt", 32'(sample_cnt), 32'd3);
        check("t1_hum", 32'(hum), 32'd0);
        idle(3);

        // 2: hysteresis band value restarts the clear count
        sample(8'd44, 8'd20, 1'b0); idle(3);
        sample(8'd47, 8'd20, 1'b0); idle(3);
        sample(8'd44, 8'd20, 1'b0); idle(3);
        sample(8'd44, 8'd20, 1'b0);
        check("t2_temp_after4", 32'(temp), 32'd1);
        idle(3);
        sample(8'd44, 8'd20, 1'b0);
        check("t2_temp_after5", 32'(temp), 32'd0);
        idle(3);

        // 3: rejected frame is invisible
        sample(8'd20, 8'd95, 1'b0); idle(2);
        sample(8'd20, 8'd95, 1'b0); idle(2);
        sample(8'd20, 8'd95, 1'b1);
        check("t3_hum_after_err", 32'(hum), 32'd0);
        idle(2);
        sample(8'd20, 8'd95, 1'b0);
        check("t3_hum", 32'(hum), 32'd1);
        check("t3_cnt", 32'(sample_cnt), 32'd11);

        // 4: smoke filtering
        raw_i = 1'b1; idle(3);
        raw_i = 1'b0; idle(10);
        check("t4_pulse_rejected", 32'(smoke), 32'd0);
        raw_i = 1'b1; idle(5);
        check("t4_smoke_before", 32'(smoke), 32'd0);
        idle(1);
        check("t4_smoke_set", 32'(smoke), 32'd1);
        raw_i = 1'b0; idle(2);
        raw_i = 1'b1; idle(8);
        check("t4_glitch_ignored", 32'(smoke), 32'd1);
        raw_i = 1'b0; idle(20);
        check("t4_smoke_clear", 32'(smoke), 32'd0);

        // 5: stale sensor
        sample(8'd20, 8'd20, 1'b0);
        idle(99);
        check("t5_fault_99", 32'(sensor_fault), 32'd0);
        idle(1);
        check("t5_fault_100", 32'(sensor_fault), 32'd1);
        check("t5_temp_hold", 32'(temp), 32'd0);
        check("t5_hum_hold", 32'(hum), 32'd1);
        sample(8'd20, 8'd95, 1'b0);
        check("t5_fault_cleared", 32'(sensor_fault), 32'd0);
        idle(99);
        sample(8'd20, 8'd95, 1'b0);
        check("t5_fault_race", 32'(sensor_fault), 32'd0);
        idle(2);

        // 6: reset mid-confirm with smoke filtering in progress
        sample(8'd52, 8'd20, 1'b0); idle(2);
        sample(8'd52, 8'd20, 1'b0);
        raw_i = 1'b1; idle(3);
        rst_i = 1'b1; step();
        rst_i = 1'b0; raw_i = 1'b0;
        check("t6_temp", 32'(temp), 32'd0);
        check("t6_hum", 32'(hum), 32'd0);
        check("t6_smoke", 32'(smoke), 32'd0);
        check("t6_fault", 32'(sensor_fault), 32'd0);
        check("t6_cnt", 32'(sample_cnt), 32'd0);
        sample(8'd52, 8'd20, 1'b0); idle(2);
        sample(8'd52, 8'd20, 1'b0); idle(2);
        check("t6_temp_after2", 32'(temp), 32'd0);
        sample(8'd52, 8'd20, 1'b0);
        check("t6_temp_after3", 32'(temp), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 5) == 0) raw_i = ~raw_i;
            if ($urandom_range(0, 2) == 0) begin
                dv_i  = 1'b1;
                err_i = ($urandom_range(0, 7) == 0);
                td_i  = pick(T_HI, T_LO);
                hd_i  = pick(H_HI, H_LO);
            end else begin
                dv_i  = 1'b0;
                err_i = 1'($urandom_range(0, 1));
                td_i  = 8'($urandom_range(0, 255));
                hd_i  = 8'($urandom_range(0, 255));
            end
            step();
            if ($urandom_range(0, 399) == 0) begin
                rst_i = 1'b0; dv_i = 1'b0;
                idle(110);
            end
        end
        rst_i = 1'b0; dv_i = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
